// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, the "no register"
// id, pipeline register layouts and their bubble (NOP) values.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [1:0] AOK = 2'd0;
  localparam logic [1:0] HLT = 2'd1;
  localparam logic [1:0] ADR = 2'd2;
  localparam logic [1:0] INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  // E/M pipeline register
  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } em_t;

  // M/W pipeline register
  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } mw_t;

  localparam em_t EmBubble = '{stat: AOK, icode: INOP, val_e: 64'd0, val_a: 64'd0,
                               dst_e: RNONE, dst_m: RNONE};
  localparam mw_t MwBubble = '{stat: AOK, icode: INOP, val_e: 64'd0, val_m: 64'd0,
                               dst_e: RNONE, dst_m: RNONE};

  // Memory clear FSM states (used only when MEM_CLEAR_EN is defined)
  typedef enum logic {StClear, StRun} clr_state_e;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: DEPTH x 64-bit, asynchronous read, synchronous write.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data (combinational)
module data_mem #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [63:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [63:0]       rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: E/M pipeline register, data memory access, memory-stage
// status, and M/W pipeline register.
// Optional feature: define MEM_CLEAR_EN to zero the data memory after reset
// (m_busy high for DEPTH cycles); otherwise m_busy is tied low.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   e_stall, e_bubble        E/M register hold / bubble (stall wins)
//   w_stall                  M/W register hold, also suppresses the memory write
//   E_stat..E_dstM, e_cnd,
//   e_valE                   execute-stage results
//   m_stat                   combinational memory-stage status
//   m_busy                   memory clear in progress
//   W_*                      M/W register contents
module mem_stage
  import y86_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_stall,
  input  logic        e_bubble,
  input  logic        w_stall,
  input  logic [1:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] E_valA,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  output logic [1:0]  m_stat,
  output logic        m_busy,
  output logic [1:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  em_t em_q, em_d;
  mw_t mw_q, mw_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              is_read, is_write, addr_err, instr_we;
  logic [63:0]       mem_addr, rd_data, val_m;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [63:0]       mem_wdata;

  // ---------------------------------------------------------------------------
  // Memory clear FSM
  // ---------------------------------------------------------------------------
`ifdef MEM_CLEAR_EN
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == StClear) begin
      clr_we = ~rst;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d = StRun;
      end
    end
  end

  assign clr_addr = cnt_q;
  assign m_busy   = (state_q == StClear);
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign m_busy   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // E/M register
  // ---------------------------------------------------------------------------
  always_comb begin
    em_d = em_q;
    if (e_stall || m_busy) begin
      em_d = em_q;
    end else if (e_bubble) begin
      em_d = EmBubble;
    end else begin
      em_d.stat  = E_stat;
      em_d.icode = E_icode;
      em_d.val_e = e_valE;
      em_d.val_a = E_valA;
      // A not-taken conditional move writes no register
      em_d.dst_e = (E_icode == IRRMOVQ && !e_cnd) ? RNONE : E_dstE;
      em_d.dst_m = E_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_q <= EmBubble;
    end else begin
      em_q <= em_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory access and status
  // ---------------------------------------------------------------------------
  always_comb begin
    is_read  = (em_q.icode == IMRMOVQ) || (em_q.icode == IPOPQ) || (em_q.icode == IRET);
    is_write = (em_q.icode == IRMMOVQ) || (em_q.icode == IPUSHQ) || (em_q.icode == ICALL);
    mem_addr = ((em_q.icode == IPOPQ) || (em_q.icode == IRET)) ? em_q.val_a : em_q.val_e;
    // Full 64-bit compare so high address bits cannot alias into the array
    addr_err = (is_read || is_write) && (mem_addr >= 64'(DEPTH));
    m_stat   = addr_err ? ADR : em_q.stat;
    val_m    = (is_read && !addr_err) ? rd_data : 64'd0;
    // Once an exception reaches write-back, no later store may commit
    instr_we = is_write && (m_stat == AOK) && (mw_q.stat == AOK) && !w_stall && !m_busy;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = mem_addr[ADDR_W-1:0];
    mem_wdata = em_q.val_a;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = 64'd0;
    end else if (instr_we && !rst) begin
      mem_we = 1'b1;
    end
  end

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (mem_addr[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  // ---------------------------------------------------------------------------
  // M/W register
  // ---------------------------------------------------------------------------
  always_comb begin
    mw_d = mw_q;
    if (w_stall) begin
      mw_d = mw_q;
    end else if (m_busy) begin
      mw_d = MwBubble;
    end else begin
      mw_d.stat  = m_stat;
      mw_d.icode = em_q.icode;
      mw_d.val_e = em_q.val_e;
      mw_d.val_m = val_m;
      mw_d.dst_e = em_q.dst_e;
      mw_d.dst_m = em_q.dst_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mw_q <= MwBubble;
    end else begin
      mw_q <= mw_d;
    end
  end

  assign W_stat  = mw_q.stat;
  assign W_icode = mw_q.icode;
  assign W_valE  = mw_q.val_e;
  assign W_valM  = mw_q.val_m;
  assign W_dstE  = mw_q.dst_e;
  assign W_dstM  = mw_q.dst_m;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of instructions pushed through the
// stage with a scoreboard queue, plus hand-written stall/bubble/reset sequences.
module tb_mem_stage;
  import y86_pkg::*;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  logic        clk, rst, e_stall, e_bubble, w_stall, e_cnd;
  logic [1:0]  E_stat, m_stat, W_stat;
  logic [3:0]  E_icode, E_dstE, E_dstM, W_icode, W_dstE, W_dstM;
  logic [63:0] e_valE, E_valA, W_valE, W_valM;
  logic        m_busy;

  mem_stage #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .e_stall  (e_stall),
    .e_bubble (e_bubble),
    .w_stall  (w_stall),
    .E_stat   (E_stat),
    .E_icode  (E_icode),
    .e_cnd    (e_cnd),
    .e_valE   (e_valE),
    .E_valA   (E_valA),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .m_stat   (m_stat),
    .m_busy   (m_busy),
    .W_stat   (W_stat),
    .W_icode  (W_icode),
    .W_valE   (W_valE),
    .W_valM   (W_valM),
    .W_dstE   (W_dstE),
    .W_dstM   (W_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [1:0]  x_stat;
    logic [63:0] x_val_m;
    logic [3:0]  x_dst_e;
  } vec_t;

  typedef struct {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic [1:0] st, logic [3:0] ic, logic c, logic [63:0] ve,
                              logic [63:0] va, logic [3:0] de, logic [3:0] dm,
                              logic [1:0] xs, logic [63:0] xm, logic [3:0] xde);
    vec_t v;
    v.stat = st; v.icode = ic; v.cnd = c; v.val_e = ve; v.val_a = va;
    v.dst_e = de; v.dst_m = dm; v.x_stat = xs; v.x_val_m = xm; v.x_dst_e = xde;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    E_stat = v.stat; E_icode = v.icode; e_cnd = v.cnd; e_valE = v.val_e;
    E_valA = v.val_a; E_dstE = v.dst_e; E_dstM = v.dst_m;
  endtask

  // Drive one instruction, record its expected W_* values, and compare the
  // instruction that reaches write-back on this edge.
  task automatic sb_cycle(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    e.stat = v.x_stat; e.icode = v.icode; e.val_e = v.val_e;
    e.val_m = v.x_val_m; e.dst_e = v.x_dst_e; e.dst_m = v.dst_m;
    sb.push_back(e);
    tick();
    chk({tag, " m_stat"}, 64'(m_stat), 64'(v.x_stat));
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      chk({tag, " W_stat"},  64'(W_stat),  64'(e.stat));
      chk({tag, " W_icode"}, 64'(W_icode), 64'(e.icode));
      chk({tag, " W_valE"},  W_valE,       e.val_e);
      chk({tag, " W_valM"},  W_valM,       e.val_m);
      chk({tag, " W_dstE"},  64'(W_dstE),  64'(e.dst_e));
      chk({tag, " W_dstM"},  64'(W_dstM),  64'(e.dst_m));
    end
  endtask

  task automatic wait_not_busy(input string tag, output int n);
    n = 0;
    while (m_busy && n < 2000) begin
      tick();
      n++;
    end
    if (m_busy) chk({tag, " busy timeout"}, 64'(m_busy), 64'd0);
  endtask

  vec_t nop;
  int   n;

  initial begin
    nop = mk(AOK, INOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE, AOK, 64'd0, RNONE);
    rst = 1'b1; e_stall = 1'b0; e_bubble = 1'b0; w_stall = 1'b0;
    drive(nop);

    // Instruction table: inputs and expected stat / valM / dstE at write-back
`ifdef MEM_CLEAR_EN
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd0,   0, RNONE, 4'd1, AOK, 64'd0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd100, 0, RNONE, 4'd1, AOK, 64'd0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd255, 0, RNONE, 4'd1, AOK, 64'd0, RNONE));
`endif
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'd5,     64'hDEAD, RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd5,     0,        RNONE, 4'd2,  AOK, 64'hDEAD, RNONE));
    vecs.push_back(mk(AOK, IPUSHQ,  0, 64'hFF,    64'd7,    4'd4,  RNONE, AOK, 0, 4'd4));
    vecs.push_back(mk(AOK, IPOPQ,   0, 64'h100,   64'hFF,   4'd4,  4'd1,  AOK, 64'd7, 4'd4));
    vecs.push_back(mk(AOK, IRRMOVQ, 0, 64'h11,    0,        4'd3,  RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IRRMOVQ, 1, 64'h11,    0,        4'd3,  RNONE, AOK, 0, 4'd3));
    vecs.push_back(mk(AOK, IIRMOVQ, 1, 64'h42,    0,        4'd6,  RNONE, AOK, 0, 4'd6));
    vecs.push_back(mk(AOK, ICALL,   1, 64'h80,    64'h1234, 4'd4,  RNONE, AOK, 0, 4'd4));
    vecs.push_back(mk(AOK, IRET,    1, 64'h88,    64'h80,   4'd4,  RNONE, AOK, 64'h1234, 4'd4));
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'd3,     64'h33,   RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'h20,    64'h77,   RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'd255,   64'hFFEE, RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd255,   0,        RNONE, 4'd8,  AOK, 64'hFFEE, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd256,   0,        RNONE, 4'd9,  ADR, 0, RNONE));
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'd3,     64'hBAD,  RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'd3,     0,        RNONE, 4'd2,  AOK, 64'h33, RNONE));
    vecs.push_back(mk(HLT, IHALT,   0, 64'd0,     0,        RNONE, RNONE, HLT, 0, RNONE));
    vecs.push_back(mk(AOK, IRMMOVQ, 0, 64'h20,    64'h99,   RNONE, RNONE, AOK, 0, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'h20,    0,        RNONE, 4'd3,  AOK, 64'h77, RNONE));
    vecs.push_back(mk(AOK, IMRMOVQ, 0, 64'h1_0000_0005, 0,  RNONE, 4'd3,  ADR, 0, RNONE));
    vecs.push_back(mk(AOK, IPOPQ,   0, 64'h1008,  64'h1000, 4'd4,  4'd5,  ADR, 0, 4'd4));
    vecs.push_back(mk(INS, IOPQ,    1, 64'h5,     0,        4'd2,  RNONE, INS, 0, 4'd2));

    // Reset state
    tick(); tick();
    chk("rst W_stat",  64'(W_stat),  64'(AOK));
    chk("rst W_icode", 64'(W_icode), 64'(INOP));
    chk("rst W_valE",  W_valE, 64'd0);
    chk("rst W_valM",  W_valM, 64'd0);
    chk("rst W_dstE",  64'(W_dstE), 64'(RNONE));
    chk("rst W_dstM",  64'(W_dstM), 64'(RNONE));
`ifdef MEM_CLEAR_EN
    chk("rst m_busy", 64'(m_busy), 64'd1);
    rst = 1'b0;
    wait_not_busy("clear1", n);
    chk("clear1 cycles", 64'(n), 64'(DEPTH));
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (100) tick();
    chk("clear2 busy@100", 64'(m_busy), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    wait_not_busy("clear2", n);
    chk("clear2 cycles", 64'(n), 64'(DEPTH));
`else
    chk("rst m_busy", 64'(m_busy), 64'd0);
    rst = 1'b0;
`endif

    // Table-driven run through the scoreboard, then drain
    for (int i = 0; i < vecs.size(); i++) sb_cycle(vecs[i], $sformatf("v%0d", i));
    sb_cycle(nop, "drain0");
    sb_cycle(nop, "drain1");
    sb.delete();

    // e_stall: held instruction repeats at write-back, new input not captured
    drive(mk(AOK, IIRMOVQ, 1, 64'hA1, 0, 4'd1, RNONE, AOK, 0, 4'd1));
    tick();
    e_stall = 1'b1;
    drive(mk(AOK, IIRMOVQ, 1, 64'hB2, 0, 4'd2, RNONE, AOK, 0, 4'd2));
    tick(); chk("estall1 W_valE", W_valE, 64'hA1);
    tick(); chk("estall2 W_valE", W_valE, 64'hA1);
    chk("estall2 W_dstE", 64'(W_dstE), 64'd1);
    e_stall = 1'b0;
    tick(); chk("estall3 W_valE", W_valE, 64'hA1);
    tick(); chk("estall4 W_valE", W_valE, 64'hB2);

    // e_bubble: a NOP bubble replaces the instruction
    e_bubble = 1'b1;
    drive(mk(AOK, IIRMOVQ, 1, 64'hC3, 0, 4'd3, RNONE, AOK, 0, 4'd3));
    tick(); e_bubble = 1'b0; drive(nop);
    tick();
    chk("ebubble W_icode", 64'(W_icode), 64'(INOP));
    chk("ebubble W_dstE",  64'(W_dstE),  64'(RNONE));
    chk("ebubble W_valE",  W_valE, 64'd0);

    // w_stall: W holds and the store in M is dropped
    drive(mk(AOK, IRMMOVQ, 0, 64'h30, 64'h11, RNONE, RNONE, AOK, 0, RNONE));
    tick(); drive(nop);
    tick(); drive(mk(AOK, IRMMOVQ, 0, 64'h30, 64'h22, RNONE, RNONE, AOK, 0, RNONE));
    tick();
    w_stall = 1'b1;
    drive(mk(AOK, IMRMOVQ, 0, 64'h30, 0, RNONE, 4'd5, AOK, 0, RNONE));
    tick(); chk("wstall W_icode held", 64'(W_icode), 64'(INOP));
    w_stall = 1'b0; drive(nop);
    tick();
    chk("wstall rd W_icode", 64'(W_icode), 64'(IMRMOVQ));
    chk("wstall rd W_valM",  W_valM, 64'h11);

    // Reset mid-operation: both registers bubble, pending store dropped
    drive(mk(AOK, IRMMOVQ, 0, 64'h40, 64'h5, RNONE, RNONE, AOK, 0, RNONE));
    tick(); drive(nop);
    tick(); drive(mk(AOK, IRMMOVQ, 0, 64'h40, 64'h66, RNONE, RNONE, AOK, 0, RNONE));
    tick();
    rst = 1'b1; drive(nop);
    tick(); rst = 1'b0;
    chk("midrst W_icode", 64'(W_icode), 64'(INOP));
    chk("midrst W_dstE",  64'(W_dstE),  64'(RNONE));
`ifdef MEM_CLEAR_EN
    wait_not_busy("midrst", n);
    chk("midrst clear cycles", 64'(n), 64'(DEPTH));
`endif
    drive(mk(AOK, IMRMOVQ, 0, 64'h40, 0, RNONE, 4'd7, AOK, 0, RNONE));
    tick(); drive(nop);
    tick();
`ifdef MEM_CLEAR_EN
    chk("midrst rd W_valM", W_valM, 64'd0);
`else
    chk("midrst rd W_valM", W_valM, 64'h5);
`endif
    chk("midrst rd W_dstM", 64'(W_dstM), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined Y86-64 core, directly downstream of the execute stage. It captures execute results into the E/M pipeline register, reads and writes a word-addressed data memory, computes the memory-stage status and registers the results into the M/W pipeline register for write-back. It also exposes combinational status so the pipeline controller can stall, bubble and suppress writes.

## Interface
- DEPTH, 256: data memory size in 64-bit words; must be a power of two.
- ADDR_W, $clog2(DEPTH): word-index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- e_stall  in  1  hold the E/M register.
- e_bubble  in  1  load a NOP bubble into the E/M register; `e_stall` wins if both are high.
- w_stall  in  1  hold the M/W register and suppress the memory write.
- E_stat  in  2  status from execute: AOK=0, HLT=1, ADR=2, INS=3.
- E_icode  in  4  instruction code.
- e_cnd  in  1  condition result from execute.
- e_valE  in  64  ALU result or effective address.
- E_valA  in  64  store data, or valP for call, or old %rsp for popq/ret.
- E_dstE  in  4  destination for valE; 0xF means none.
- E_dstM  in  4  destination for valM.
- m_stat  out  2  combinational status of the instruction in the memory stage.
- m_busy  out  1  memory clear in progress.
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  2/4/64/64/4/4  M/W register contents.

## Operation
- E/M register load:
  - Captures the execute outputs.
  - For icode 2 (rrmovq/cmovXX) with `e_cnd`=0, stores `M_dstE`=0xF.
- Bubble value for either register: stat=AOK, icode=1 (NOP), valE=valM=0, dstE=dstM=0xF.
- Memory read instructions and their address:
  - mrmovq (5): address `M_valE`.
  - popq (11) and ret (9): address `M_valA`.
- Memory write instructions, always at address `M_valE`:
  - rmmovq (4): data `M_valA`.
  - pushq (10): data `M_valA`.
  - call (8): data `M_valA` (valP).
- Address error: the 64-bit address is ≥ DEPTH (unsigned compare on all 64 bits, no truncation).
- `m_stat`:
  - ADR when a read or write instruction has an address error.
  - Otherwise `M_stat`.
- `valM`:
  - Combinational read of mem[addr[ADDR_W-1:0]] when the instruction is a read and the address is legal.
  - Otherwise 0.
- Write enable = write instruction AND `m_stat`==AOK AND `W_stat`==AOK AND !`w_stall` AND !`m_busy`. Writes are blocked after any exception has reached write-back.
- M/W register:
  - Loads `m_stat`, `M_icode`, `M_valE`, `valM`, `M_dstE`, `M_dstM`.
  - Holds when `w_stall` is high.
- No bypass is needed for a read at the address written in the same cycle: one instruction per cycle, and a later reader sees the value written at the preceding edge.

## Timing
- Reset: both pipeline registers hold the bubble value, and `W_*` outputs equal the bubble. `m_busy` is 0 without MEM_CLEAR_EN and 1 with it.
- Latency: `E_*` inputs sampled at edge N appear on `W_*` after edge N+1.
- Memory write commits at the same edge that loads the M/W register.
- While `m_busy`=1:
  - The E/M register holds, behaving as if `e_stall` were high.
  - The M/W register loads bubbles.
  - No instruction write occurs.
- `rst` asserted mid-operation: both registers return to bubble at that edge and any pending write is dropped.

## Configuration
- MEM_CLEAR_EN defined: a clear FSM with states CLEAR and RUN.
  - `rst` enters CLEAR with the counter at 0.
  - Each cycle writes 0 to mem[counter] and increments the counter.
  - After word DEPTH-1 it enters RUN and drops `m_busy`. `m_busy` is high for exactly DEPTH cycles after the reset edge.
  - `rst` during CLEAR restarts the counter at 0.
- MEM_CLEAR_EN undefined:
  - No FSM.
  - `m_busy` is tied to 0.
  - Memory contents are unaffected by reset (undefined until written).

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (IHALT…IPOPQ).
  - stat codes AOK/HLT/ADR/INS.
  - RNONE=4'hF.
  - The bubble defaults.
- One sub-module, `data_mem`:
  - DEPTH×64 array.
  - Asynchronous read, synchronous write.
  - Clear write port muxed in by `mem_stage`.

## Test plan
- rmmovq with `e_valE`=5 and `E_valA`=0xDEAD, then mrmovq with `e_valE`=5 → second instruction gives `W_valM`=0xDEAD and `W_dstM`=its dstM.
- pushq with `e_valE`=0xFF and `E_valA`=7, then popq with `E_valA`=0xFF and `e_valE`=0x100 → `W_valM`=7 and `W_valE`=0x100.
- mrmovq with `e_valE`=256 (DEPTH 256) → `m_stat`=ADR and `W_stat`=ADR. A following rmmovq to address 3 does not change mem[3].
- cmov with `e_cnd`=0 and `E_dstE`=3 → `W_dstE`=0xF. With `e_cnd`=1 → `W_dstE`=3.
- `e_stall` for 2 cycles → `W_*` repeats the held instruction without re-capturing; `e_bubble` → `W_icode`=1 and `W_dstE`=0xF. `w_stall` with rmmovq in M → no write.
- MEM_CLEAR_EN: pulse `rst` → `m_busy` is high for 256 cycles and all words read 0. Re-asserting `rst` at cycle 100 → `m_busy` stays high 256 more cycles.
